// File: rtl/rssi_pkg.sv
// Shared types and constants for the RSSI forward-model generator.
// Holds the sequencer state encoding, word widths and the RSSI encoding defaults.
package rssi_pkg;

    localparam int COORD_W = 8;
    localparam int DSQ_W   = 17;
    localparam int DIST_W  = 9;
    localparam int RSSI_W  = 20;

    localparam logic [RSSI_W-1:0] RSSI_BASE_DEFAULT  = 20'h3AFFF;
    localparam int unsigned       RSSI_SCALE_DEFAULT = 20;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQX  = 3'd1,
        SQY  = 3'd2,
        ROOT = 3'd3,
        ENC  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Constant scale factor expanded into shifted adds; with scale=20 this
    // reduces to (d<<4)+(d<<2), so no multiplier is inferred.
    function automatic logic [RSSI_W-1:0] scale_dist(input logic [DIST_W-1:0] d,
                                                     input int unsigned scale);
        logic [RSSI_W-1:0] s;
        s = '0;
        for (int i = 0; i < 12; i++) begin
            if (scale[i]) begin
                s = s + (RSSI_W'(d) << i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: one result bit per cycle, MSB first,
// nine iterations for a 17-bit radicand. Shift/subtract only.
module isqrt_seq
    import rssi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DSQ_W-1:0]  radicand,
    output logic [DIST_W-1:0] root,
    output logic              done
);

    logic [DSQ_W:0]      rad_reg;
    logic [DIST_W:0]     rem_reg;
    logic [DIST_W-1:0]   root_reg;
    logic [3:0]          cnt_reg;
    logic                run_reg;

    logic [DIST_W+2:0]   rem_trial;
    logic [DIST_W+2:0]   trial;
    logic                fits;

    // Remainder never exceeds 2*root (<= 720), so 10 bits hold it between steps.
    assign rem_trial = {rem_reg, rad_reg[DSQ_W:DSQ_W-1]};
    assign trial     = {1'b0, root_reg, 2'b01};
    assign fits      = (rem_trial >= trial);

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_reg  <= '0;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
        end else if (start) begin
            rad_reg  <= {1'b0, radicand};
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b1;
        end else if (run_reg) begin
            rad_reg  <= {rad_reg[DSQ_W-2:0], 2'b00};
            rem_reg  <= fits ? (DIST_W+1)'(rem_trial - trial) : (DIST_W+1)'(rem_trial);
            root_reg <= {root_reg[DIST_W-2:0], fits};
            cnt_reg  <= cnt_reg + 4'd1;
            if (cnt_reg == 4'd8) begin
                run_reg <= 1'b0;
            end
        end
    end

    assign root = root_reg;
    assign done = run_reg && (cnt_reg == 4'd8);

endmodule

// File: rtl/rssi_synth.sv
// Forward model for the trilateration path: per anchor, floor Euclidean distance
// to the target and its inverted RSSI word, computed with one shared 8x8 multiplier.
module rssi_synth
    import rssi_pkg::*;
#(
    parameter logic [RSSI_W-1:0] RSSI_BASE  = RSSI_BASE_DEFAULT,
    parameter int unsigned       RSSI_SCALE = RSSI_SCALE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] A_x,
    input  logic [COORD_W-1:0] A_y,
    input  logic [COORD_W-1:0] B_x,
    input  logic [COORD_W-1:0] B_y,
    input  logic [COORD_W-1:0] C_x,
    input  logic [COORD_W-1:0] C_y,
    input  logic [COORD_W-1:0] xt_i,
    input  logic [COORD_W-1:0] yt_i,
    output logic               busy,
    output logic               out_valid,
    output logic [DIST_W-1:0]  distA,
    output logic [DIST_W-1:0]  distB,
    output logic [DIST_W-1:0]  distC,
    output logic [RSSI_W-1:0]  rssiA,
    output logic [RSSI_W-1:0]  rssiB,
    output logic [RSSI_W-1:0]  rssiC
);

    state_t               state_reg, state_next;
    logic [1:0]           k_reg;
    logic [DSQ_W-1:0]     acc_reg;
    logic [COORD_W-1:0]   xt_reg, yt_reg;
    logic [COORD_W-1:0]   anc_x_reg [0:2];
    logic [COORD_W-1:0]   anc_y_reg [0:2];
    logic [DIST_W-1:0]    dist_reg  [0:2];
    logic [RSSI_W-1:0]    rssi_reg  [0:2];

    logic [COORD_W-1:0]   anc_x, anc_y;
    logic [COORD_W-1:0]   dx, dy, mul_op;
    logic [2*COORD_W-1:0] prod;
    logic [DSQ_W-1:0]     dsq_sum;
    logic                 accept;
    logic                 sq_start, sq_done;
    logic [DIST_W-1:0]    root;
    logic [RSSI_W-1:0]    rssi_enc;

    wire [COORD_W-1:0] in_x [0:2] = '{A_x, B_x, C_x};
    wire [COORD_W-1:0] in_y [0:2] = '{A_y, B_y, C_y};

    assign accept = (state_reg == IDLE) && start;

    // Input capture: all coordinates are frozen at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            xt_reg <= '0;
            yt_reg <= '0;
        end else if (accept) begin
            xt_reg <= xt_i;
            yt_reg <= yt_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_anchor
            always_ff @(posedge clk) begin
                if (rst) begin
                    anc_x_reg[gi] <= '0;
                    anc_y_reg[gi] <= '0;
                end else if (accept) begin
                    anc_x_reg[gi] <= in_x[gi];
                    anc_y_reg[gi] <= in_y[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dist_reg[gi] <= '0;
                    rssi_reg[gi] <= '0;
                end else if ((state_reg == ENC) && (k_reg == 2'(gi))) begin
                    dist_reg[gi] <= root;
                    rssi_reg[gi] <= rssi_enc;
                end
            end
        end
    endgenerate

    // Single shared multiplier: squares dx in SQX and dy in SQY.
    assign anc_x   = anc_x_reg[k_reg];
    assign anc_y   = anc_y_reg[k_reg];
    assign dx      = (xt_reg >= anc_x) ? (xt_reg - anc_x) : (anc_x - xt_reg);
    assign dy      = (yt_reg >= anc_y) ? (yt_reg - anc_y) : (anc_y - yt_reg);
    assign mul_op  = (state_reg == SQX) ? dx : dy;
    assign prod    = {8'd0, mul_op} * {8'd0, mul_op};
    assign dsq_sum = acc_reg + {1'b0, prod};

    assign sq_start = (state_reg == SQY);

    isqrt_seq u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sq_start),
        .radicand (dsq_sum),
        .root     (root),
        .done     (sq_done)
    );

    assign rssi_enc = ~(RSSI_BASE + scale_dist(root, RSSI_SCALE));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            k_reg   <= '0;
        end else begin
            if (state_reg == SQX) begin
                acc_reg <= {1'b0, prod};
            end else if (state_reg == SQY) begin
                acc_reg <= dsq_sum;
            end
            if (accept) begin
                k_reg <= '0;
            end else if ((state_reg == ENC) && (k_reg != 2'd2)) begin
                k_reg <= k_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SQX;
            SQX:     state_next = SQY;
            SQY:     state_next = ROOT;
            ROOT:    if (sq_done) state_next = ENC;
            ENC:     state_next = (k_reg == 2'd2) ? DONE : SQX;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        out_valid = (state_reg == DONE);
    end

    assign distA = dist_reg[0];
    assign distB = dist_reg[1];
    assign distC = dist_reg[2];
    assign rssiA = rssi_reg[0];
    assign rssiB = rssi_reg[1];
    assign rssiC = rssi_reg[2];

endmodule

// File: tb/tb_rssi_synth.sv
// Directed bench for rssi_synth: hand-computed geometries, timing, start
// filtering, back-to-back runs, mid-run reset, then random geometries.
module tb_rssi_synth;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A_x = '0, A_y = '0, B_x = '0, B_y = '0, C_x = '0, C_y = '0;
    logic [7:0] xt_i = '0, yt_i = '0;
    logic       busy, out_valid;
    logic [8:0] distA, distB, distC;
    logic [19:0] rssiA, rssiB, rssiC;

    int checks = 0;
    int errors = 0;
    int vcyc;
    int pulses;

    always #5 clk = ~clk;

    rssi_synth dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A_x       (A_x),
        .A_y       (A_y),
        .B_x       (B_x),
        .B_y       (B_y),
        .C_x       (C_x),
        .C_y       (C_y),
        .xt_i      (xt_i),
        .yt_i      (yt_i),
        .busy      (busy),
        .out_valid (out_valid),
        .distA     (distA),
        .distB     (distB),
        .distC     (distC),
        .rssiA     (rssiA),
        .rssiB     (rssiB),
        .rssiC     (rssiC)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_geom(input logic [7:0] xt, input logic [7:0] yt,
                            input logic [7:0] ax, input logic [7:0] ay,
                            input logic [7:0] bx, input logic [7:0] by,
                            input logic [7:0] cx, input logic [7:0] cy);
        xt_i = xt; yt_i = yt;
        A_x = ax; A_y = ay; B_x = bx; B_y = by; C_x = cx; C_y = cy;
    endtask

    task automatic check_out(input int da, input int db, input int dc,
                             input logic [19:0] ra, input logic [19:0] rb, input logic [19:0] rc);
        chk("distA", 32'(distA), 32'(da));
        chk("distB", 32'(distB), 32'(db));
        chk("distC", 32'(distC), 32'(dc));
        chk("rssiA", 32'(rssiA), 32'(ra));
        chk("rssiB", 32'(rssiB), 32'(rb));
        chk("rssiC", 32'(rssiC), 32'(rc));
        $display("run xt=%0d yt=%0d dist=%0d/%0d/%0d rssi=%05h/%05h/%05h",
                 xt_i, yt_i, distA, distB, distC, rssiA, rssiB, rssiC);
    endtask

    // Pulse start for one cycle and return the cycle in which out_valid was
    // seen (cycle 1 is the one right after the acceptance edge); 0 on timeout.
    task automatic run_once(output int vc);
        @(negedge clk);
        start = 1'b1;
        vc = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                vc = c;
                break;
            end
        end
    endtask

    function automatic int isqrt_ref(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [19:0] rssi_ref(input int d);
        logic [19:0] s;
        s = 20'h3AFFF + 20'(20 * d);
        return ~s;
    endfunction

    function automatic int dist_ref(input int xt, input int yt, input int x, input int y);
        return isqrt_ref((xt - x) * (xt - x) + (yt - y) * (yt - y));
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        check_out(0, 0, 0, 20'h0, 20'h0, 20'h0);

        // Test 1: 3-4-5 geometry with out_valid timing and busy window
        set_geom(8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd6, 8'd8);
        @(negedge clk);
        start = 1'b1;
        vcyc = 0;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1)  chk("busy_c1", 32'(busy), 32'd1);
            if (c == 37) chk("busy_c37", 32'(busy), 32'd1);
            if (c == 38) chk("busy_c38", 32'(busy), 32'd0);
            if (out_valid) begin
                pulses++;
                vcyc = c;
            end
        end
        chk("valid_cycle", 32'(vcyc), 32'd37);
        chk("valid_pulses", 32'(pulses), 32'd1);
        check_out(5, 0, 10, 20'hC4F9C, 20'hC5000, 20'hC4F38);

        // Test 2: extreme geometry
        set_geom(8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd254, 8'd254);
        run_once(vcyc);
        chk("t2_latency", 32'(vcyc), 32'd37);
        check_out(360, 255, 1, 20'hC33E0, 20'hC3C14, 20'hC4FEC);

        // Test 3: non-square radicands
        set_geom(8'd2, 8'd3, 8'd0, 8'd0, 8'd1, 8'd2, 8'd1, 8'd1);
        run_once(vcyc);
        chk("t3_latency", 32'(vcyc), 32'd37);
        check_out(3, 1, 2, 20'hC4FC4, 20'hC4FEC, 20'hC4FD8);

        set_geom(8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd4, 8'd5);
        run_once(vcyc);
        check_out(1, 0, 5, 20'hC4FEC, 20'hC5000, 20'hC4F9C);

        // Test 4: start pulses and input changes during a run are ignored
        set_geom(8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd6, 8'd8);
        @(negedge clk);
        start = 1'b1;
        vcyc = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 20);
            if (c == 5) set_geom(8'd200, 8'd17, 8'd90, 8'd9, 8'd1, 8'd250, 8'd33, 8'd44);
            if (out_valid && vcyc == 0) vcyc = c;
        end
        chk("t4_latency", 32'(vcyc), 32'd37);
        chk("t4_idle", 32'(busy), 32'd0);
        check_out(5, 0, 10, 20'hC4F9C, 20'hC5000, 20'hC4F38);

        // Test 5: start held high -> back-to-back runs
        set_geom(8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd254, 8'd254);
        @(negedge clk);
        start = 1'b1;
        pulses = 0;
        vcyc = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 39) start = 1'b0;
            if (c == 38) chk("b2b_busy_c38", 32'(busy), 32'd0);
            if (c == 39) chk("b2b_busy_c39", 32'(busy), 32'd1);
            if (out_valid) begin
                pulses++;
                if (pulses == 1) chk("b2b_first", 32'(c), 32'd37);
                if (pulses == 2) vcyc = c;
            end
        end
        chk("b2b_second", 32'(vcyc), 32'd75);
        check_out(360, 255, 1, 20'hC33E0, 20'hC3C14, 20'hC4FEC);

        // Test 6: reset during ROOT of anchor B, then a clean run
        set_geom(8'd2, 8'd3, 8'd0, 8'd0, 8'd1, 8'd2, 8'd1, 8'd1);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_distA", 32'(distA), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        check_out(0, 0, 0, 20'h0, 20'h0, 20'h0);
        set_geom(8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd6, 8'd8);
        run_once(vcyc);
        chk("post_rst_latency", 32'(vcyc), 32'd37);
        check_out(5, 0, 10, 20'hC4F9C, 20'hC5000, 20'hC4F38);

        // Test 7: random geometries against the reference model
        for (int n = 0; n < 200; n++) begin
            int da, db, dc;
            set_geom(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            da = dist_ref(int'(xt_i), int'(yt_i), int'(A_x), int'(A_y));
            db = dist_ref(int'(xt_i), int'(yt_i), int'(B_x), int'(B_y));
            dc = dist_ref(int'(xt_i), int'(yt_i), int'(C_x), int'(C_y));
            run_once(vcyc);
            chk("rnd_latency", 32'(vcyc), 32'd37);
            check_out(da, db, dc, rssi_ref(da), rssi_ref(db), rssi_ref(dc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
